ps2_keyboard_ascii: RTL and testbench
=====================================

# ps2_keyboard_ascii

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` lines and decodes scan-code set 2 make/break sequences. It tracks the shift, ctrl and caps-lock modifiers and emits one ASCII event per mapped key press or release. It sits between the board PS/2 pins and the view-control logic in `clk_sys`, which acts on `ascii_new && key_pressed`.

## Interface
- `clk_freq`, default 33333333: `clk` frequency in Hz; sets the idle timeout.
- `ps2_debounce_counter_size`, default 8: N; a line must be stable for 2^N cycles before the debounced value follows it.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `ps2_clk`, input, 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`, input, 1: raw PS/2 data, asynchronous to `clk`.
- `ascii_new`, output, 1: single-cycle pulse; the event is valid.
- `key_pressed`, output, 1: 1 = make (press), 0 = break (release); valid with `ascii_new`.
- `ascii_code`, output, 8: ASCII value (bit 7 = 0); valid with `ascii_new`.

## Operation
- **Reset.** On reset all of the following clear to 0: outputs, modifiers, break and extended flags, bit count and shift register.
- **Input conditioning.** Each raw line passes a 2-FF synchronizer, then a debouncer.
  - The debouncer output takes the synchronized value once it has been stable for 2^N consecutive cycles.
- **Frame receive.**
  - On each falling edge of debounced `ps2_clk`, sample debounced `ps2_data` into an 11-bit shift register, LSB first: start, d0..d7, odd parity, stop.
  - Idle timeout IDLE = clk_freq/18000 cycles (about 55.6 µs).
  - When debounced `ps2_clk` has been high for IDLE cycles:
    - With 11 bits received and start=0, stop=1 and odd parity over d0..d7+parity correct, the frame is valid: present the byte to the decoder.
    - In all other cases, discard the frame.
    - In both cases, clear the bit count.
  - A 12th falling edge before the idle timeout discards the frame.
- **Decoder.**
  - Byte F0: set the break flag.
  - Byte E0: set the extended flag.
  - Any other byte: process it with the current flags, then clear both flags.
- **Modifiers.**
  - 12 or 59 = shift. 14 or E0 14 = ctrl.
  - Each is held while made and cleared on break.
  - 58 = caps lock: toggles on a make only when caps was previously released, so typematic repeats do not toggle. Caps-lock state clears only on reset.
  - Modifier keys never produce events.
- **Mapping.**
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
    - Lowercase by default. Uppercase when shift XOR caps.
    - With ctrl held: code = lowercase - 0x60 (0x01..0x1A); ctrl has priority over the case rule.
  - Digits 16..45 ('1'..'9','0'): 16,1E,26,25,2E,36,3D,3E,46,45.
    - With shift: !@#$%^&*().
  - Others:
    - 29 -> 0x20.
    - 5A and E0 5A -> 0x0D.
    - 66 -> 0x08.
    - 0D -> 0x09.
    - 76 -> 0x1B.
    - 4E '-'/'_'.
    - 55 '='/'+'.
    - 41 ','/'<'.
    - 49 '.'/'>'.
    - 4A '/'/'?'.
  - Unmapped codes and other E0 codes: no event, flags still cleared.
- **Events.**
  - A mapped make: `ascii_new` pulse with `key_pressed`=1. Typematic repeats of a make produce further pulses.
  - A mapped break: `ascii_new` pulse with `key_pressed`=0. The code is computed with the modifiers current at the release.

## Timing
- `ascii_code` and `key_pressed` update in the same cycle `ascii_new` rises, and hold until the next event.
- `ascii_new` is high for exactly 1 cycle, 2 cycles after the idle timeout completes on a valid frame.
- Minimum event spacing is one frame, so no back-pressure is needed.
- Reset asserted mid-frame: the partial frame and all flags are lost.
- A glitch shorter than 2^N cycles on either line has no effect.

## Test plan
Bench settings: clk_freq=1000000, N=3, PS/2 bit period 80 µs.
- **Lowercase press.** Frame 1C -> `ascii_new` 1 cycle, `ascii_code`=0x61, `key_pressed`=1.
- **Break.** Frames F0,1C -> exactly one pulse, 0x61, `key_pressed`=0. No pulse after the F0 frame alone.
- **Shift and caps.**
  - 12, then 1D -> 0x57 'W'.
  - F0 12, then 58, F0 58, 1D -> 0x57.
  - Then 12, 1D -> 0x77.
- **Ctrl and extended.**
  - 14, then 15 -> 0x11.
  - E0 5A -> 0x0D.
  - E0 75 -> no pulse; flags clear, so a following 1B -> 0x73.
- **Bad frame.** Parity-error frame for 1C, or a 10-bit frame, -> no pulse. The next good 24 -> 0x65.
- **Reset and glitch.**
  - `reset_n` low mid-frame -> outputs 0. The next full frame 2D -> 0x72.
  - A 5-cycle `ps2_clk` glitch causes no bit shift.

Source files
------------

// File: rtl/ps2_keyboard_ascii.sv
// PS/2 keyboard receiver: conditions the raw lines, assembles 11-bit frames and
// decodes scan-code set 2 make/break sequences into ASCII press/release events.
module ps2_keyboard_ascii #(
   parameter int clk_freq                  = 33333333,
   parameter int ps2_debounce_counter_size = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ascii_new,
   output logic       key_pressed,
   output logic [7:0] ascii_code
);

   localparam int N    = ps2_debounce_counter_size;
   localparam int IDLE = clk_freq / 18000;
   localparam int IW   = $clog2(IDLE + 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE - 1);

   logic [1:0]   rawLines;
   logic [1:0]   sync1_q, sync2_q, deb_q;
   logic [N-1:0] debCnt_q [2];

   assign rawLines = {ps2_data, ps2_clk};

   // Lines idle high; a debounced line only moves after 2^N cycles of disagreement.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '1;
         for (int i = 0; i < 2; i++) debCnt_q[i] <= '0;
      end else begin
         sync1_q <= rawLines;
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               debCnt_q[i] <= '0;
            end else if (debCnt_q[i] == '1) begin
               deb_q[i]    <= sync2_q[i];
               debCnt_q[i] <= '0;
            end else begin
               debCnt_q[i] <= debCnt_q[i] + N'(1);
            end
         end
      end
   end

   logic          debClk, debData, prevClk_q, clkFall, idleDone, frameOk;
   logic [3:0]    bitCount_q;
   logic [10:0]   shiftReg_q;
   logic [IW-1:0] idleCnt_q;
   logic          byteValid_q;
   logic [7:0]    rxByte_q;

   assign debClk   = deb_q[0];
   assign debData  = deb_q[1];
   assign clkFall  = prevClk_q & ~debClk;
   assign idleDone = debClk && (idleCnt_q == IDLE_LAST);
   assign frameOk  = (bitCount_q == 4'd11) && !shiftReg_q[0] && shiftReg_q[10]
                     && (^shiftReg_q[9:1]);

   // Bit count saturates at 12 so an over-long frame stays invalid until idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prevClk_q   <= 1'b1;
         bitCount_q  <= '0;
         shiftReg_q  <= '0;
         idleCnt_q   <= '0;
         byteValid_q <= 1'b0;
         rxByte_q    <= '0;
      end else begin
         prevClk_q   <= debClk;
         byteValid_q <= 1'b0;
         if (!debClk) idleCnt_q <= '0;
         else if (idleCnt_q != IDLE_MAX) idleCnt_q <= idleCnt_q + IW'(1);
         if (clkFall) begin
            shiftReg_q <= {debData, shiftReg_q[10:1]};
            if (bitCount_q != 4'd12) bitCount_q <= bitCount_q + 4'd1;
         end else if (idleDone) begin
            bitCount_q <= '0;
            if (frameOk) begin
               byteValid_q <= 1'b1;
               rxByte_q    <= shiftReg_q[8:1];
            end
         end
      end
   end

   logic [7:0] lc, plain, shifted;

   // Lowercase letter value, or plain/shifted pair for the other mapped keys; 0 = unmapped.
   always_comb begin
      lc      = 8'h00;
      plain   = 8'h00;
      shifted = 8'h00;
      case (rxByte_q)
         8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
         8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
         8'h43: lc = 8'h69;  8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
         8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;  8'h4D: lc = 8'h70;
         8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;  8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;
         8'h3C: lc = 8'h75;  8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
         8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
         8'h16: {plain, shifted} = {8'h31, 8'h21};
         8'h1E: {plain, shifted} = {8'h32, 8'h40};
         8'h26: {plain, shifted} = {8'h33, 8'h23};
         8'h25: {plain, shifted} = {8'h34, 8'h24};
         8'h2E: {plain, shifted} = {8'h35, 8'h25};
         8'h36: {plain, shifted} = {8'h36, 8'h5E};
         8'h3D: {plain, shifted} = {8'h37, 8'h26};
         8'h3E: {plain, shifted} = {8'h38, 8'h2A};
         8'h46: {plain, shifted} = {8'h39, 8'h28};
         8'h45: {plain, shifted} = {8'h30, 8'h29};
         8'h4E: {plain, shifted} = {8'h2D, 8'h5F};
         8'h55: {plain, shifted} = {8'h3D, 8'h2B};
         8'h41: {plain, shifted} = {8'h2C, 8'h3C};
         8'h49: {plain, shifted} = {8'h2E, 8'h3E};
         8'h4A: {plain, shifted} = {8'h2F, 8'h3F};
         8'h29: {plain, shifted} = {8'h20, 8'h20};
         8'h5A: {plain, shifted} = {8'h0D, 8'h0D};
         8'h66: {plain, shifted} = {8'h08, 8'h08};
         8'h0D: {plain, shifted} = {8'h09, 8'h09};
         8'h76: {plain, shifted} = {8'h1B, 8'h1B};
         default: ;
      endcase
   end

   logic       brk_q, brk_d, ext_q, ext_d, shift_q, shift_d, ctrl_q, ctrl_d;
   logic       caps_q, caps_d, capsDown_q, capsDown_d;
   logic       asciiNew_q, asciiNew_d, keyPressed_q, keyPressed_d;
   logic [7:0] asciiCode_q, asciiCode_d;

   // capsDown remembers a held caps key so typematic repeats do not toggle caps again.
   always_comb begin
      brk_d        = brk_q;
      ext_d        = ext_q;
      shift_d      = shift_q;
      ctrl_d       = ctrl_q;
      caps_d       = caps_q;
      capsDown_d   = capsDown_q;
      asciiNew_d   = 1'b0;
      keyPressed_d = keyPressed_q;
      asciiCode_d  = asciiCode_q;
      if (byteValid_q) begin
         if (rxByte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (rxByte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (!ext_q && (rxByte_q == 8'h12 || rxByte_q == 8'h59)) begin
               shift_d = !brk_q;
            end else if (rxByte_q == 8'h14) begin
               ctrl_d = !brk_q;
            end else if (!ext_q && rxByte_q == 8'h58) begin
               capsDown_d = !brk_q;
               if (!brk_q && !capsDown_q) caps_d = !caps_q;
            end else if (ext_q) begin
               if (rxByte_q == 8'h5A) begin
                  asciiNew_d   = 1'b1;
                  keyPressed_d = !brk_q;
                  asciiCode_d  = 8'h0D;
               end
            end else if (lc != 8'h00) begin
               asciiNew_d   = 1'b1;
               keyPressed_d = !brk_q;
               if (ctrl_q) asciiCode_d = lc - 8'h60;
               else if (shift_q ^ caps_q) asciiCode_d = lc - 8'h20;
               else asciiCode_d = lc;
            end else if (plain != 8'h00) begin
               asciiNew_d   = 1'b1;
               keyPressed_d = !brk_q;
               asciiCode_d  = shift_q ? shifted : plain;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         shift_q      <= 1'b0;
         ctrl_q       <= 1'b0;
         caps_q       <= 1'b0;
         capsDown_q   <= 1'b0;
         asciiNew_q   <= 1'b0;
         keyPressed_q <= 1'b0;
         asciiCode_q  <= 8'h00;
      end else begin
         brk_q        <= brk_d;
         ext_q        <= ext_d;
         shift_q      <= shift_d;
         ctrl_q       <= ctrl_d;
         caps_q       <= caps_d;
         capsDown_q   <= capsDown_d;
         asciiNew_q   <= asciiNew_d;
         keyPressed_q <= keyPressed_d;
         asciiCode_q  <= asciiCode_d;
      end
   end

   assign ascii_new   = asciiNew_q;
   assign key_pressed = keyPressed_q;
   assign ascii_code  = asciiCode_q;

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Bench for ps2_keyboard_ascii: drives PS/2 frames, predicts events with a
// table-driven keyboard model and checks them from a separate monitor.
`timescale 1ns/1ps
module tb_ps2_keyboard_ascii;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       ascii_new, key_pressed;
   logic [7:0] ascii_code;

   int compared = 0;
   int mismatched = 0;

   typedef struct packed {
      logic       kp;
      logic [7:0] code;
   } event_t;
   event_t expQ [$];

   ps2_keyboard_ascii #(
      .clk_freq(1000000),
      .ps2_debounce_counter_size(3)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .ascii_new(ascii_new),
      .key_pressed(key_pressed),
      .ascii_code(ascii_code)
   );

   // 1 MHz system clock
   always #500 clk = ~clk;

   // Keyboard model: key tables plus modifier/flag state
   logic [7:0] letterSc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                 8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                 8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] digitSc [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
   logic [7:0] punctSc [5]  = '{8'h4E,8'h55,8'h41,8'h49,8'h4A};
   logic [7:0] fixSc [5]    = '{8'h29,8'h5A,8'h66,8'h0D,8'h76};
   logic [7:0] fixCode [5]  = '{8'h20,8'h0D,8'h08,8'h09,8'h1B};
   string digitStr   = "1234567890";
   string digitShift = "!@#$%^&*()";
   string punctStr   = "-=,./";
   string punctShift = "_+<>?";
   bit mShift, mCtrl, mCaps, mCapsDown, mBrk, mExt;

   task automatic modelReset();
      mShift = 0; mCtrl = 0; mCaps = 0; mCapsDown = 0; mBrk = 0; mExt = 0;
   endtask

   task automatic expectEvent(input logic [7:0] code);
      event_t e;
      e.kp   = !mBrk;
      e.code = code;
      expQ.push_back(e);
   endtask

   task automatic modelByte(input logic [7:0] b);
      if (b == 8'hF0) mBrk = 1;
      else if (b == 8'hE0) mExt = 1;
      else begin
         if (!mExt && (b == 8'h12 || b == 8'h59)) mShift = !mBrk;
         else if (b == 8'h14) mCtrl = !mBrk;
         else if (!mExt && b == 8'h58) begin
            if (mBrk) mCapsDown = 0;
            else begin
               if (!mCapsDown) mCaps = !mCaps;
               mCapsDown = 1;
            end
         end else if (mExt) begin
            if (b == 8'h5A) expectEvent(8'h0D);
         end else begin
            for (int i = 0; i < 26; i++)
               if (letterSc[i] == b) begin
                  if (mCtrl) expectEvent(8'(i + 1));
                  else if (mShift != mCaps) expectEvent(8'(8'h41 + i));
                  else expectEvent(8'(8'h61 + i));
               end
            for (int i = 0; i < 10; i++)
               if (digitSc[i] == b) expectEvent(8'(mShift ? digitShift[i] : digitStr[i]));
            for (int i = 0; i < 5; i++)
               if (punctSc[i] == b) expectEvent(8'(mShift ? punctShift[i] : punctStr[i]));
            for (int i = 0; i < 5; i++)
               if (fixSc[i] == b) expectEvent(fixCode[i]);
         end
         mBrk = 0;
         mExt = 0;
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [10:0] frameOf(input logic [7:0] b, input logic badParity);
      return {1'b1, ~(^b) ^ badParity, b, 1'b0};
   endfunction

   // 80 us bit period; data changes mid-high so it is settled at the falling edge
   task automatic sendRaw(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         #20000 ps2_clk = 1'b0;
         #40000 ps2_clk = 1'b1;
         #20000;
      end
      ps2_data = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic badParity, input int nBits);
      if (!badParity && nBits == 11) modelByte(b);
      sendRaw(frameOf(b, badParity), nBits);
      #140000;
      checkOutput($sformatf("pending events after byte %02h", b), expQ.size(), 0);
      expQ.delete();
   endtask

   // Monitor: every pulse must match the oldest prediction and last one cycle
   bit prevNew = 0;
   always @(negedge clk) begin
      event_t e;
      if (reset_n && ascii_new) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected event: got kp=%0b code=0x%02h, expected none",
                     key_pressed, ascii_code);
         end else begin
            e = expQ.pop_front();
            if ({key_pressed, ascii_code} !== {e.kp, e.code}) begin
               mismatched++;
               $display("[TB] FAIL event: got kp=%0b code=0x%02h, expected kp=%0b code=0x%02h",
                        key_pressed, ascii_code, e.kp, e.code);
            end
         end
         compared++;
         if (prevNew) begin
            mismatched++;
            $display("[TB] FAIL pulse width: got ascii_new high 2+ cycles, expected 1");
         end
      end
      prevNew = ascii_new;
   end

   logic [7:0] pool [28] = '{8'hF0,8'hF0,8'hE0,8'h12,8'h59,8'h14,8'h58,8'h1C,8'h32,8'h21,
                             8'h1D,8'h15,8'h1A,8'h16,8'h1E,8'h45,8'h29,8'h5A,8'h66,8'h0D,
                             8'h76,8'h4E,8'h55,8'h41,8'h49,8'h4A,8'h05,8'h75};

   initial begin
      modelReset();
      #3000;
      checkOutput("reset ascii_new", int'(ascii_new), 0);
      checkOutput("reset key_pressed", int'(key_pressed), 0);
      checkOutput("reset ascii_code", int'(ascii_code), 0);
      reset_n = 1'b1;
      #100000;

      // Press, break, shift/caps, ctrl/extended sequences
      applyStimulus(8'h1C, 0, 11);
      applyStimulus(8'hF0, 0, 11);
      applyStimulus(8'h1C, 0, 11);
      applyStimulus(8'h12, 0, 11);
      applyStimulus(8'h1D, 0, 11);
      applyStimulus(8'hF0, 0, 11);
      applyStimulus(8'h12, 0, 11);
      applyStimulus(8'h58, 0, 11);
      applyStimulus(8'h58, 0, 11);
      applyStimulus(8'hF0, 0, 11);
      applyStimulus(8'h58, 0, 11);
      applyStimulus(8'h1D, 0, 11);
      applyStimulus(8'h12, 0, 11);
      applyStimulus(8'h1D, 0, 11);
      applyStimulus(8'hF0, 0, 11);
      applyStimulus(8'h12, 0, 11);
      applyStimulus(8'h14, 0, 11);
      applyStimulus(8'h15, 0, 11);
      applyStimulus(8'hF0, 0, 11);
      applyStimulus(8'h14, 0, 11);
      applyStimulus(8'hE0, 0, 11);
      applyStimulus(8'h5A, 0, 11);
      applyStimulus(8'hE0, 0, 11);
      applyStimulus(8'h75, 0, 11);
      applyStimulus(8'h58, 0, 11);
      applyStimulus(8'hF0, 0, 11);
      applyStimulus(8'h58, 0, 11);
      applyStimulus(8'h1B, 0, 11);

      // Parity error, short frame, then a good frame
      applyStimulus(8'h1C, 1, 11);
      applyStimulus(8'h1C, 0, 10);
      applyStimulus(8'h24, 0, 11);

      // Reset in the middle of a frame
      sendRaw(frameOf(8'h2D, 0), 5);
      ps2_clk = 1'b0;
      #10000 reset_n = 1'b0;
      #1;
      checkOutput("mid-frame reset ascii_new", int'(ascii_new), 0);
      checkOutput("mid-frame reset ascii_code", int'(ascii_code), 0);
      checkOutput("mid-frame reset key_pressed", int'(key_pressed), 0);
      #3000 ps2_clk = 1'b1;
      #5000 reset_n = 1'b1;
      modelReset();
      expQ.delete();
      #140000;
      applyStimulus(8'h2D, 0, 11);

      // Short clock glitch while idle must not shift a bit into the next frame
      ps2_clk = 1'b0;
      #5000 ps2_clk = 1'b1;
      #20000;
      applyStimulus(8'h1C, 0, 11);

      // Random byte stream with occasional corrupted frames
      for (int i = 0; i < 30; i++)
         applyStimulus(pool[$urandom_range(0, 27)], ($urandom_range(0, 9) == 0), 11);

      checkOutput("queue drained", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
